// File: rtl/dual_slope_meas_ctrl_if.sv
// Result handshake bus between the measurement controller and the
// display/readout logic. The controller is the master (drives the result
// fields and valid); the consumer is the slave (drives ready).
interface dual_slope_meas_ctrl_if #(
  parameter int CYC_W = 8
);
  logic                res_valid_o;
  logic                res_ready_i;
  logic [CYC_W-1:0]    cycles_o;
  logic [9:0]          start_cnt_o;
  logic [9:0]          end_cnt_o;
  logic [CYC_W+9:0]    elapsed_o;
  logic                timeout_o;

  modport master (
    output res_valid_o,
    output cycles_o,
    output start_cnt_o,
    output end_cnt_o,
    output elapsed_o,
    output timeout_o,
    input  res_ready_i
  );

  modport slave (
    input  res_valid_o,
    input  cycles_o,
    input  start_cnt_o,
    input  end_cnt_o,
    input  elapsed_o,
    input  timeout_o,
    output res_ready_i
  );
endinterface

// File: rtl/dual_slope_meas_ctrl.sv
// Dual-slope measurement controller.
// Starts the 0..999 pulse counter, counts its once-per-1000-clock increment
// pulses, snapshots the counter at window start and at capture, and hands the
// elapsed clock count to the readout logic over a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | counter stopped, waiting for start_i
// S_ARM   | one-cycle trigger strobe to the pulse counter
// S_COUNT | window open; count increments until cmp_i or MAX_CYC
// S_DONE  | result valid, counter stopped, waiting for res_ready_i
module dual_slope_meas_ctrl #(
  parameter int CYC_W   = 8,
  parameter int MAX_CYC = 200
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  cmp_i,
  input  logic                  incr_i,
  input  logic [9:0]            pulse_count_i,
  output logic                  trig_o,
  output logic                  stop_o,
  output logic                  busy_o,
  dual_slope_meas_ctrl_if.master res_if
);

  localparam int EW = CYC_W + 10;
  localparam logic [CYC_W-1:0] MAX_C = CYC_W'(MAX_CYC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic             trig_q;
  logic             busy_q;
  logic             valid_q;
  logic             first_q;
  logic             timeout_q;
  logic [CYC_W-1:0] cycles_q;
  logic [9:0]       p0_q;
  logic [9:0]       pe_q;
  logic [EW-1:0]    elapsed_q;

  logic             capture;
  logic             moved;
  logic [9:0]       p0_eff;
  logic [EW-1:0]    wraps_d;
  logic [EW-1:0]    elapsed_d;

  // Capture detection and elapsed-clock arithmetic for the current COUNT cycle.
  // Elapsed is rebuilt from the number of 999->0 wraps inside the window.
  // Every counted increment (count==998) produces a wrap one cycle later,
  // except when capture lands on 999 (wrap not yet happened). A window that
  // starts on 999 has one wrap with no counted increment in front of it.
  // Both corrections only apply once the counter has actually moved.
  always_comb begin
    capture   = (state_q == S_COUNT) && (cmp_i || (cycles_q == MAX_C));
    moved     = ~first_q;
    p0_eff    = first_q ? pulse_count_i : p0_q;
    wraps_d   = EW'(cycles_q);
    if (moved && (p0_eff == 10'd999)) begin
      wraps_d = wraps_d + EW'(1);
    end
    if (moved && (pulse_count_i == 10'd999)) begin
      wraps_d = wraps_d - EW'(1);
    end
    elapsed_d = wraps_d * EW'(1000) + EW'(pulse_count_i) - EW'(p0_eff);
  end

  // Stop is decoded from state so the counter is halted from the first cycle
  // after reset, and is raised combinationally on the capture cycle so the
  // counter freezes at the captured value.
  always_comb begin
    stop_o = (state_q == S_IDLE) || (state_q == S_DONE) || capture;
  end

  // Sequencing FSM with registered strobes and result registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      timeout_q <= 1'b0;
      cycles_q  <= '0;
      p0_q      <= '0;
      pe_q      <= '0;
      elapsed_q <= '0;
    end else begin
      trig_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q   <= S_ARM;
            trig_q    <= 1'b1;
            busy_q    <= 1'b1;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
          end
        end
        S_ARM: begin
          state_q <= S_COUNT;
          first_q <= 1'b1;
        end
        S_COUNT: begin
          first_q <= 1'b0;
          if (first_q) begin
            p0_q <= pulse_count_i;
          end
          if (capture) begin
            pe_q      <= pulse_count_i;
            timeout_q <= ~cmp_i;
            elapsed_q <= elapsed_d;
            busy_q    <= 1'b0;
            valid_q   <= 1'b1;
            state_q   <= S_DONE;
          end else if (incr_i && (cycles_q < MAX_C)) begin
            cycles_q <= cycles_q + CYC_W'(1);
          end
        end
        S_DONE: begin
          if (res_if.res_ready_i) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign trig_o             = trig_q;
  assign busy_o             = busy_q;
  assign res_if.res_valid_o = valid_q;
  assign res_if.cycles_o    = cycles_q;
  assign res_if.start_cnt_o = p0_q;
  assign res_if.end_cnt_o   = pe_q;
  assign res_if.elapsed_o   = elapsed_q;
  assign res_if.timeout_o   = timeout_q;

endmodule

// File: tb/tb_dual_slope_meas_ctrl.sv
// Bench for dual_slope_meas_ctrl: a behavioural pulse counter drives the
// controller, a driver issues measurements and pushes the expected result,
// and a monitor compares whatever the controller presents.
module tb_dual_slope_meas_ctrl;
  localparam int CYC_W   = 8;
  localparam int MAX_CYC = 3;
  localparam int EW      = CYC_W + 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic       cmp;
  logic       trig;
  logic       stop;
  logic       busy;
  logic [9:0] cnt;
  logic       run = 1'b0;
  logic       preset_en;
  logic [9:0] preset_val;
  logic       incr;

  assign incr = (cnt == 10'd998);

  dual_slope_meas_ctrl_if #(.CYC_W(CYC_W)) rif ();

  dual_slope_meas_ctrl #(.CYC_W(CYC_W), .MAX_CYC(MAX_CYC)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start),
    .cmp_i         (cmp),
    .incr_i        (incr),
    .pulse_count_i (cnt),
    .trig_o        (trig),
    .stop_o        (stop),
    .busy_o        (busy),
    .res_if        (rif)
  );

  // Pulse counter: trig enables, stop disables with priority, counts 0..999.
  always @(posedge clk) begin
    if (preset_en) cnt <= preset_val;
    else if (run && !stop) cnt <= (cnt == 10'd999) ? 10'd0 : cnt + 10'd1;
    if (stop) run <= 1'b0;
    else if (trig) run <= 1'b1;
  end

  typedef struct {
    int cyc;
    int p0;
    int pe;
    int el;
    int to;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: window of L counting cycles from p0, cmp rising at index L.
  // Increments appear at indices where (p0+i)%1000==998; MAX_CYC of them
  // force capture on the following cycle.
  function automatic exp_t model(input int p0, input int L);
    exp_t e;
    int i0, t, k;
    i0 = (998 - p0 + 1000) % 1000;
    t  = i0 + 1000 * (MAX_CYC - 1) + 1;
    k  = (L <= t) ? L : t;
    e.cyc = (k <= i0) ? 0 : (k - 1 - i0) / 1000 + 1;
    e.p0  = p0;
    e.pe  = (p0 + k) % 1000;
    e.el  = k;
    e.to  = (L > t) ? 1 : 0;
    return e;
  endfunction

  // Monitor: every cycle a result is presented it must match the oldest
  // expectation; it is retired on the handshake.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && rif.res_valid_o) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got valid=1 expected no result pending");
      end else begin
        chk("res_cycles",  int'(rif.cycles_o),    q[0].cyc);
        chk("res_p0",      int'(rif.start_cnt_o), q[0].p0);
        chk("res_pe",      int'(rif.end_cnt_o),   q[0].pe);
        chk("res_elapsed", int'(rif.elapsed_o),   q[0].el);
        chk("res_timeout", int'(rif.timeout_o),   q[0].to);
        if (rif.res_ready_i) void'(q.pop_front());
      end
    end
  end

  task automatic preset(input int v);
    @(negedge clk);
    preset_en  = 1'b1;
    preset_val = 10'(v);
    @(negedge clk);
    preset_en  = 1'b0;
  endtask

  task automatic run_meas(input int p0, input int L, input int hold, input bit poke);
    exp_t e;
    int   w;
    preset(p0);
    e = model(p0, L);
    q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("arm_trig", int'(trig), 1);
    repeat (L + 1) @(negedge clk);
    cmp = 1'b1;
    w = 0;
    while (!rif.res_valid_o && w < 6000) begin
      @(negedge clk);
      w++;
    end
    #1;
    if (!rif.res_valid_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_valid: got no result after %0d cycles expected res_valid", w);
    end
    chk("cnt_frozen", int'(cnt), e.pe);
    chk("done_stop", int'(stop), 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start = poke;
    end
    @(negedge clk);
    start = 1'b0;
    rif.res_ready_i = 1'b1;
    @(negedge clk);
    rif.res_ready_i = 1'b0;
    cmp = 1'b0;
    #1;
    chk("ack_idle", int'({busy, rif.res_valid_o, stop}), 1);
    @(negedge clk);
    #1;
    chk("no_requeue", int'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cmp   = 1'b0;
    preset_en  = 1'b1;
    preset_val = 10'd0;
    rif.res_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stop",    int'(stop), 1);
    chk("rst_flags",   int'({busy, trig, rif.res_valid_o, rif.timeout_o}), 0);
    chk("rst_cycles",  int'(rif.cycles_o), 0);
    chk("rst_elapsed", int'(rif.elapsed_o), 0);
    preset_en = 1'b0;
    rst_n = 1'b1;

    run_meas(0, 2500, 3, 1'b0);
    run_meas(700, 299, 0, 1'b0);
    run_meas(0, 4000, 2, 1'b0);
    run_meas(123, 1500, 10, 1'b1);
    run_meas(456, 0, 1, 1'b0);
    run_meas(999, 1000, 1, 1'b0);
    run_meas(998, 1, 0, 1'b0);
    run_meas(999, 0, 0, 1'b0);

    // Reset in the middle of a window.
    preset(10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1200) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_stop",   int'(stop), 1);
    chk("midrst_flags",  int'({busy, rif.res_valid_o}), 0);
    chk("midrst_cycles", int'(rif.cycles_o), 0);
    rst_n = 1'b1;

    for (int n = 0; n < 12; n++) begin
      run_meas(int'($urandom % 1000), int'($urandom_range(0, 3200)),
               int'($urandom_range(0, 4)), bit'($urandom % 2));
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
